// File: rtl/prog_address_decoder_if.sv
// ============================================================================
// Module      : prog_address_decoder_if
// Description : Bus/config bundle between a 68K-style CPU and the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prog_address_decoder_if #(
  parameter int NUM_REGIONS = 8,
  parameter int IDX_W       = $clog2(NUM_REGIONS)
);
  logic [31:0]            Address;
  logic                   AS_L;
  logic                   Dtack_In_L;
  logic                   Cfg_WE_H;
  logic [IDX_W-1:0]       Cfg_Index;
  logic [1:0]             Cfg_Field;
  logic [31:0]            Cfg_WData;
  logic [NUM_REGIONS-1:0] Select_H;
  logic                   Unmapped_H;
  logic                   Overlap_H;
  logic                   BusError_L;
  logic                   Fault_Valid_H;
  logic [31:0]            Fault_Address;

  modport master (
    output Address, AS_L, Dtack_In_L, Cfg_WE_H, Cfg_Index, Cfg_Field, Cfg_WData,
    input  Select_H, Unmapped_H, Overlap_H, BusError_L, Fault_Valid_H, Fault_Address
  );

  modport slave (
    input  Address, AS_L, Dtack_In_L, Cfg_WE_H, Cfg_Index, Cfg_Field, Cfg_WData,
    output Select_H, Unmapped_H, Overlap_H, BusError_L, Fault_Valid_H, Fault_Address
  );
endinterface

`default_nettype wire

// File: rtl/prog_address_decoder.sv
// ============================================================================
// Module      : prog_address_decoder
// Description : Programmable base/mask/enable decoder with registered one-hot
//               selects, unmapped/timeout bus error. Optional fault capture
//               enabled by defining ADDRDEC_FAULT_CAPTURE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_address_decoder #(
  parameter int NUM_REGIONS = 8,
  parameter int TIMEOUT     = 255,
  parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
  input  logic                  Clk,
  input  logic                  Reset_H,
  prog_address_decoder_if.slave bus
);

  localparam int          CNT_W          = 16;
  localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_timeoutM1 = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0] c_numRegions   = 32'(NUM_REGIONS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BERR   = 2'd2
  } state_t;

  function automatic logic [31:0] defBase(input int idx);
    case (idx)
      1:       return 32'hF000_0000;
      2:       return 32'h0040_0000;
      3:       return 32'h0800_0000;
      4:       return 32'h0050_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] defMask(input int idx);
    case (idx)
      0:       return 32'hFFFF_8000;
      1:       return 32'hFFFC_0000;
      2:       return 32'hFFFF_0000;
      3:       return 32'hFC00_0000;
      4:       return 32'hFFFF_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  logic [31:0]            r_base [NUM_REGIONS];
  logic [31:0]            r_mask [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] r_en;

  state_t                 r_state;
  logic [NUM_REGIONS-1:0] r_select;
  logic                   r_unmapped;
  logic                   r_overlap;
  logic                   r_busErrorL;
  logic [CNT_W-1:0]       r_count;

  logic [NUM_REGIONS-1:0] w_hit;
  logic [NUM_REGIONS-1:0] w_sel;
  logic                   w_overlap;
  logic                   w_idxValid;
  logic                   w_timeoutHit;
  logic                   w_berrEntry;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      w_hit[i] = r_en[i] && ((bus.Address & r_mask[i]) == (r_base[i] & r_mask[i]));
    end
  end

  // Scan from the top so the lowest-index hit is the one left standing.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
  end

  assign w_overlap    = |(w_hit & (w_hit - NUM_REGIONS'(1)));
  assign w_idxValid   = ({{(32-IDX_W){1'b0}}, bus.Cfg_Index} < c_numRegions);
  assign w_timeoutHit = bus.Dtack_In_L && (r_count == c_timeoutM1);
  assign w_berrEntry  = (r_state == ACTIVE) && !bus.AS_L && (r_unmapped || w_timeoutHit);

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_base[i] <= defBase(i);
        r_mask[i] <= defMask(i);
        r_en[i]   <= (i <= 4);
      end
    end else if (bus.Cfg_WE_H && w_idxValid) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (bus.Cfg_Index == IDX_W'(i)) begin
          case (bus.Cfg_Field)
            2'd0:    r_base[i] <= bus.Cfg_WData;
            2'd1:    r_mask[i] <= bus.Cfg_WData;
            2'd2:    r_en[i]   <= bus.Cfg_WData[0];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      r_state     <= IDLE;
      r_select    <= '0;
      r_unmapped  <= 1'b0;
      r_overlap   <= 1'b0;
      r_busErrorL <= 1'b1;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.AS_L) begin
            r_select   <= w_sel;
            r_unmapped <= ~|w_hit;
            r_overlap  <= w_overlap;
            r_state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.AS_L) begin
            r_state     <= IDLE;
            r_select    <= '0;
            r_unmapped  <= 1'b0;
            r_overlap   <= 1'b0;
            r_busErrorL <= 1'b1;
            r_count     <= '0;
          end else begin
            if (bus.Dtack_In_L && (r_count != c_timeout)) begin
              r_count <= r_count + CNT_W'(1);
            end
            if (w_berrEntry) begin
              r_busErrorL <= 1'b0;
              r_state     <= BERR;
            end
          end
        end
        BERR: begin
          if (bus.AS_L) begin
            r_state     <= IDLE;
            r_select    <= '0;
            r_unmapped  <= 1'b0;
            r_overlap   <= 1'b0;
            r_busErrorL <= 1'b1;
            r_count     <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Select_H   = r_select;
  assign bus.Unmapped_H = r_unmapped;
  assign bus.Overlap_H  = r_overlap;
  assign bus.BusError_L = r_busErrorL;

`ifdef ADDRDEC_FAULT_CAPTURE_EN
  logic [31:0] r_cycleAddr;
  logic [31:0] r_faultAddr;
  logic        r_faultValid;

  // Capture is only possible while clear, so a same-clock clear never loses it.
  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      r_cycleAddr  <= '0;
      r_faultAddr  <= '0;
      r_faultValid <= 1'b0;
    end else begin
      if ((r_state == IDLE) && !bus.AS_L) begin
        r_cycleAddr <= bus.Address;
      end
      if (w_berrEntry && !r_faultValid) begin
        r_faultAddr  <= r_cycleAddr;
        r_faultValid <= 1'b1;
      end else if (bus.Cfg_WE_H && w_idxValid && (bus.Cfg_Field == 2'd3)) begin
        r_faultValid <= 1'b0;
      end
    end
  end

  assign bus.Fault_Valid_H = r_faultValid;
  assign bus.Fault_Address = r_faultAddr;
`else
  assign bus.Fault_Valid_H = 1'b0;
  assign bus.Fault_Address = 32'h0000_0000;
`endif

endmodule

`default_nettype wire
